// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S processor: instruction decode, controller states,
// ALU operation codes and the bundled controller output word.
package k_and_s_pkg;

    localparam int unsigned INSTR_W  = 4;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [INSTR_W-1:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    typedef enum logic [STATE_W-1:0] {
        FETCH       = 4'd0,
        DECODE      = 4'd1,
        LOAD_WAIT   = 4'd2,
        LOAD_WB     = 4'd3,
        STORE       = 4'd4,
        MOVE        = 4'd5,
        ALU         = 4'd6,
        BRANCH_EVAL = 4'd7,
        HALT        = 4'd8
    } ctrl_state_type;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    typedef struct packed {
        logic                halt;
        logic                ram_write_enable;
        logic                flags_reg_enable;
        logic                write_reg_enable;
        logic [ALU_OP_W-1:0] operation;
        logic                c_sel;
        logic                addr_sel;
        logic                ir_enable;
        logic                pc_enable;
        logic                branch;
    } ctrl_out_t;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle Moore controller: sequences fetch/decode/execute and drives the
// datapath enables from the current state, gated off while rst_n is low.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [ALU_OP_W-1:0]     operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_type r_state;
    ctrl_state_type w_next_state;
    ctrl_out_t      w_out;
    ctrl_out_t      w_out_gated;

    // No branch in this ISA tests signed overflow.
    logic w_unused_signed_ov;
    assign w_unused_signed_ov = signed_overflow;

    // Branch condition against the flags latched by the last ALU instruction.
    function automatic logic branch_taken(
        input decoded_instruction_type instr,
        input logic                    z,
        input logic                    n,
        input logic                    uov
    );
        logic taken;
        taken = 1'b0;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = z;
            I_BNZERO: taken = ~z;
            I_BNEG:   taken = n;
            I_BNNEG:  taken = ~n;
            I_BOV:    taken = uov;
            I_BNOV:   taken = ~uov;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_op(input decoded_instruction_type instr);
        logic [ALU_OP_W-1:0] op;
        op = ALU_ADD;
        case (instr)
            I_ADD:   op = ALU_ADD;
            I_SUB:   op = ALU_SUB;
            I_AND:   op = ALU_AND;
            I_OR:    op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_out        = '0;
        case (r_state)
            FETCH: begin
                w_out.ir_enable = 1'b1;
                w_next_state    = DECODE;
            end
            DECODE: begin
                w_out.pc_enable = 1'b1;
                case (decoded_instruction)
                    I_LOAD:                           w_next_state = LOAD_WAIT;
                    I_STORE:                          w_next_state = STORE;
                    I_MOVE:                           w_next_state = MOVE;
                    I_ADD, I_SUB, I_AND, I_OR:        w_next_state = ALU;
                    I_BRANCH, I_BZERO, I_BNZERO,
                    I_BNEG, I_BNNEG, I_BOV, I_BNOV:   w_next_state = BRANCH_EVAL;
                    I_HALT:                           w_next_state = HALT;
                    default:                          w_next_state = FETCH;
                endcase
            end
            LOAD_WAIT: begin
                w_out.addr_sel = 1'b1;
                w_next_state   = LOAD_WB;
            end
            LOAD_WB: begin
                w_out.addr_sel         = 1'b1;
                w_out.c_sel            = 1'b1;
                w_out.write_reg_enable = 1'b1;
                w_next_state           = FETCH;
            end
            STORE: begin
                w_out.addr_sel         = 1'b1;
                w_out.ram_write_enable = 1'b1;
                w_next_state           = FETCH;
            end
            MOVE: begin
                // Move is routed through the ALU as OR with itself, flags untouched.
                w_out.operation        = ALU_OR;
                w_out.write_reg_enable = 1'b1;
                w_next_state           = FETCH;
            end
            ALU: begin
                w_out.operation        = alu_op(decoded_instruction);
                w_out.write_reg_enable = 1'b1;
                w_out.flags_reg_enable = 1'b1;
                w_next_state           = FETCH;
            end
            BRANCH_EVAL: begin
                if (branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow)) begin
                    w_out.pc_enable = 1'b1;
                    w_out.branch    = 1'b1;
                    w_out.addr_sel  = 1'b1;
                end
                w_next_state = FETCH;
            end
            HALT: begin
                w_out.halt   = 1'b1;
                w_next_state = HALT;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held.
    assign w_out_gated = rst_n ? w_out : '0;

    assign branch           = w_out_gated.branch;
    assign pc_enable        = w_out_gated.pc_enable;
    assign ir_enable        = w_out_gated.ir_enable;
    assign addr_sel         = w_out_gated.addr_sel;
    assign c_sel            = w_out_gated.c_sel;
    assign operation        = w_out_gated.operation;
    assign write_reg_enable = w_out_gated.write_reg_enable;
    assign flags_reg_enable = w_out_gated.flags_reg_enable;
    assign ram_write_enable = w_out_gated.ram_write_enable;
    assign halt             = w_out_gated.halt;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-cycle output words
// compared against hand-computed patterns.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst_n;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;

    int n_tests;
    int n_fail;

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {halt, ram_we, flags_en, wr_en, op[1:0], c_sel, addr_sel, ir_en, pc_en, branch}
    logic [10:0] obs;
    assign obs = {halt, ram_write_enable, flags_reg_enable, write_reg_enable,
                  operation, c_sel, addr_sel, ir_enable, pc_enable, branch};

    localparam logic [10:0] O_ZERO   = 11'h000;
    localparam logic [10:0] O_FETCH  = 11'h004;
    localparam logic [10:0] O_DECODE = 11'h002;
    localparam logic [10:0] O_LWAIT  = 11'h008;
    localparam logic [10:0] O_LWB    = 11'h098;
    localparam logic [10:0] O_STORE  = 11'h208;
    localparam logic [10:0] O_MOVE   = 11'h0E0;
    localparam logic [10:0] O_ADD    = 11'h180;
    localparam logic [10:0] O_SUB    = 11'h1A0;
    localparam logic [10:0] O_AND    = 11'h1C0;
    localparam logic [10:0] O_OR     = 11'h1E0;
    localparam logic [10:0] O_BTAKEN = 11'h00B;
    localparam logic [10:0] O_HALT   = 11'h400;

    task automatic check(input string tag, input logic [10:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; n_extra execute-state patterns follow DECODE.
    task automatic exec(input string tag, input decoded_instruction_type instr,
                        input int n_extra, input logic [10:0] e1, input logic [10:0] e2);
        decoded_instruction = instr;
        check({tag, ".fetch"}, O_FETCH);
        tick();
        check({tag, ".decode"}, O_DECODE);
        tick();
        if (n_extra >= 1) begin
            check({tag, ".exec1"}, e1);
            tick();
        end
        if (n_extra >= 2) begin
            check({tag, ".exec2"}, e2);
            tick();
        end
    endtask

    initial begin
        decoded_instruction_type br_types [7];
        logic                    exp_f0   [7];
        logic                    exp_f1   [7];
        logic                    f;
        logic                    taken;

        n_tests = 0;
        n_fail  = 0;
        rst_n               = 1'b0;
        decoded_instruction = I_NOP;
        zero_op             = 1'b0;
        neg_op              = 1'b0;
        unsigned_overflow   = 1'b0;
        signed_overflow     = 1'b0;

        #1;
        check("reset_outputs", O_ZERO);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("first_fetch", O_FETCH);

        // NOP: FETCH, DECODE, then FETCH again
        exec("nop", I_NOP, 0, O_ZERO, O_ZERO);
        check("nop.refetch", O_FETCH);

        exec("load", I_LOAD, 2, O_LWAIT, O_LWB);
        exec("sub", I_SUB, 1, O_SUB, O_ZERO);

        // SUB of equal operands leaves zero flag set
        zero_op = 1'b1;
        exec("bzero_z1", I_BZERO, 1, O_BTAKEN, O_ZERO);
        zero_op = 1'b0;
        exec("bzero_z0", I_BZERO, 1, O_ZERO, O_ZERO);

        br_types = '{I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};
        exp_f0   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_f1   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int fi = 0; fi < 2; fi++) begin
            for (int b = 0; b < 7; b++) begin
                f = (fi == 1);
                // Only the tested flag carries f; the others carry its complement.
                zero_op           = ~f;
                neg_op            = ~f;
                unsigned_overflow = ~f;
                signed_overflow   = ~f;
                if (b == 1 || b == 2) zero_op = f;
                if (b == 3 || b == 4) neg_op = f;
                if (b == 5 || b == 6) unsigned_overflow = f;
                taken = f ? exp_f1[b] : exp_f0[b];
                exec($sformatf("br%0d_f%0d", b, fi), br_types[b], 1,
                     taken ? O_BTAKEN : O_ZERO, O_ZERO);
            end
        end
        zero_op = 1'b0; neg_op = 1'b0; unsigned_overflow = 1'b0; signed_overflow = 1'b0;

        exec("add",   I_ADD,   1, O_ADD,   O_ZERO);
        exec("and",   I_AND,   1, O_AND,   O_ZERO);
        exec("or",    I_OR,    1, O_OR,    O_ZERO);
        exec("move",  I_MOVE,  1, O_MOVE,  O_ZERO);
        exec("store", I_STORE, 1, O_STORE, O_ZERO);

        // Reset in the middle of STORE
        decoded_instruction = I_STORE;
        check("rst_st.fetch", O_FETCH);
        tick();
        check("rst_st.decode", O_DECODE);
        tick();
        check("rst_st.store", O_STORE);
        #2 rst_n = 1'b0;
        #1;
        check("rst_st.immediate", O_ZERO);
        tick();
        check("rst_st.held", O_ZERO);
        #2 rst_n = 1'b1;
        decoded_instruction = I_NOP;
        #1;
        check("rst_st.fetch_after", O_FETCH);
        tick();
        check("rst_st.decode_after", O_DECODE);
        tick();

        // Reset in the middle of LOAD_WAIT
        decoded_instruction = I_LOAD;
        check("rst_ld.fetch", O_FETCH);
        tick();
        check("rst_ld.decode", O_DECODE);
        tick();
        check("rst_ld.wait", O_LWAIT);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ld.immediate", O_ZERO);
        tick();
        check("rst_ld.held", O_ZERO);
        #2 rst_n = 1'b1;
        decoded_instruction = I_NOP;
        #1;
        check("rst_ld.fetch_after", O_FETCH);
        tick();
        check("rst_ld.decode_after", O_DECODE);
        tick();

        // HALT holds for 20 cycles, instruction input changed to prove it is ignored
        exec("halt", I_HALT, 0, O_ZERO, O_ZERO);
        decoded_instruction = I_ADD;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt.hold%0d", i), O_HALT);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("halt.rst_low", O_ZERO);
        #2 rst_n = 1'b1;
        decoded_instruction = I_NOP;
        #1;
        check("halt.refetch", O_FETCH);
        tick();
        check("halt.decode_after", O_DECODE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL provide these ports: clk  in  1  system clock, rising-edge active.
REQ-002 The block SHALL provide these ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL provide these ports: decoded_instruction  in  decoded_instruction_type  current IR decode from datapath.
REQ-004 The block SHALL provide these ports: zero_op, neg_op, unsigned_overflow, signed_overflow  in  1 each  registered datapath flags.
REQ-005 The block SHALL provide these ports: branch, pc_enable, ir_enable, addr_sel, c_sel  out  1 each  datapath controls.
REQ-006 The block SHALL provide these ports: operation  out  2  ALU select; write_reg_enable, flags_reg_enable  out  1 each.
REQ-007 The block SHALL provide these ports: ram_write_enable  out  1  RAM write strobe; halt  out  1  processor stopped.

Function
REQ-008 The block SHALL be a Moore FSM; all outputs SHALL be decoded from the state register, plus decoded_instruction and flags for operation and branch only; unlisted outputs are 0 in each state.
REQ-009 The block SHALL implement states FETCH, DECODE, LOAD_WAIT, LOAD_WB, STORE, MOVE, ALU, BRANCH_EVAL, HALT.
REQ-010 FETCH SHALL drive addr_sel=0, ir_enable=1, then go to DECODE.
REQ-011 DECODE SHALL drive pc_enable=1, branch=0 (PC+1), then dispatch on decoded_instruction: LOAD->LOAD_WAIT, STORE->STORE, MOVE->MOVE, ADD/SUB/AND/OR->ALU, any branch->BRANCH_EVAL, HALT->HALT, NOP or any other value->FETCH.
REQ-012 LOAD_WAIT SHALL drive addr_sel=1 for one RAM read-latency cycle, then go to LOAD_WB.
REQ-013 LOAD_WB SHALL drive addr_sel=1, c_sel=1, write_reg_enable=1, then go to FETCH.
REQ-014 STORE SHALL drive addr_sel=1, ram_write_enable=1 for exactly one cycle, then go to FETCH.
REQ-015 MOVE SHALL drive operation=OR, c_sel=0, write_reg_enable=1, flags_reg_enable=0, then go to FETCH.
REQ-016 ALU SHALL drive operation ADD=00, SUB=01, AND=10, OR=11 per decoded_instruction, c_sel=0, write_reg_enable=1, flags_reg_enable=1, then go to FETCH.
REQ-017 BRANCH_EVAL SHALL compute taken as: BRANCH always; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV unsigned_overflow; BNOV !unsigned_overflow.
REQ-018 If taken, BRANCH_EVAL SHALL drive pc_enable=1, branch=1, addr_sel=1; in all cases it SHALL go to FETCH.
REQ-019 Flags sampled in BRANCH_EVAL SHALL be those registered by the most recent ALU state; flag-write and flag-test in the same cycle cannot occur.
REQ-020 HALT SHALL drive halt=1 and SHALL remain in HALT until rst_n is asserted; other outputs are 0.
REQ-021 Instruction latency in cycles SHALL be: NOP 2, MOVE/ALU/STORE/branch 3, LOAD 4.

Reset
REQ-022 rst_n low SHALL asynchronously force state=FETCH.
REQ-023 While rst_n is low, all outputs SHALL be 0; output gating is on rst_n.
REQ-024 Reset asserted mid-instruction SHALL abandon it; no write_reg_enable, ram_write_enable or pc_enable pulse SHALL occur after the rst_n fall.
REQ-025 The first FETCH SHALL occur in the first clk edge period after rst_n rises.

Structure
REQ-026 The state enum ctrl_state_type and the ALU operation constants SHALL live in k_and_s_pkg, alongside the existing decoded_instruction_type.
REQ-027 The block SHALL be a single module with no sub-modules; the branch-condition evaluation SHALL be a local combinational function.

Verification
REQ-028 Bench SHALL cover: reset, then NOP at addr 0 -> ir_enable=1 on cycle 1, pc_enable=1 on cycle 2, FETCH again on cycle 3.
REQ-029 Bench SHALL cover: LOAD -> addr_sel=1 for 2 cycles; c_sel=1 with write_reg_enable=1 only in the 4th cycle.
REQ-030 Bench SHALL cover: SUB with equal operands, then BZERO with zero_op=1 -> branch=1, pc_enable=1 in BRANCH_EVAL; a repeat with zero_op=0 -> branch=0, pc_enable=0.
REQ-031 Bench SHALL cover: all 7 branch types x flag 0/1 -> taken exactly per the REQ-017 table; ADD/SUB/AND/OR -> operation 00/01/10/11 with flags_reg_enable=1; MOVE -> operation 11 with flags_reg_enable=0.
REQ-032 Bench SHALL cover: HALT -> halt=1 held for 20 cycles with no enables; then rst_n pulse -> halt=0 and FETCH.
REQ-033 Bench SHALL cover: rst_n asserted during STORE and during LOAD_WAIT -> all outputs 0 immediately and no later write pulse.
